// File: rtl/path_mailbox.sv
// path_mailbox: memory-mapped START/END/NODE/DONE words for the path planner,
// with a node FIFO feeding the downstream navigator over valid/ready.
module path_mailbox #(
    parameter logic [31:0] BASE_ADDR  = 32'h02000000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          CNT_W      = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ext_we,
    input  logic [31:0]      ext_addr,
    input  logic [31:0]      ext_wdata,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_hit,
    output logic             node_valid,
    output logic [31:0]      node_data,
    input  logic             node_ready,
    output logic [CNT_W-1:0] node_count,
    output logic             done,
    output logic             at_end,
    output logic             overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0]   DEPTH_OCC = FIFO_DEPTH[PTR_W:0];
    localparam logic [PTR_W:0]   OCC_ONE   = 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;

    localparam logic [1:0] IDX_START = 2'd0;
    localparam logic [1:0] IDX_END   = 2'd1;
    localparam logic [1:0] IDX_NODE  = 2'd2;
    localparam logic [1:0] IDX_DONE  = 2'd3;

    logic [31:0]      start_q, start_d;
    logic [31:0]      end_q, end_d;
    logic [31:0]      last_node_q, last_node_d;
    logic             done_q, done_d;
    logic             at_end_q, at_end_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] node_count_q, node_count_d;
    logic [31:0]      mem_q [FIFO_DEPTH];
    logic [31:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   occ_q, occ_d;

    logic       ext_hit;
    logic [1:0] ext_idx;
    logic [1:0] cpu_idx;
    logic       host_start_we, host_end_we, host_node_we, host_done_we;
    logic       core_node_we, core_done_we;
    logic       fifo_full, fifo_pop, fifo_push_ok;
    logic       unused_bits;

    assign ext_hit = (ext_addr[31:4] == BASE_ADDR[31:4]);
    assign ext_idx = ext_addr[3:2];
    assign cpu_hit = (cpu_addr[31:4] == BASE_ADDR[31:4]);
    assign cpu_idx = cpu_addr[3:2];

    assign host_start_we = ext_we && ext_hit && (ext_idx == IDX_START);
    assign host_end_we   = ext_we && ext_hit && (ext_idx == IDX_END);
    assign host_node_we  = ext_we && ext_hit && (ext_idx == IDX_NODE);
    assign host_done_we  = ext_we && ext_hit && (ext_idx == IDX_DONE);

    // The host owns a word outright when both sides write it in the same cycle.
    assign core_node_we = cpu_we && cpu_hit && (cpu_idx == IDX_NODE) && !host_node_we;
    assign core_done_we = cpu_we && cpu_hit && (cpu_idx == IDX_DONE) && !host_done_we;

    assign node_valid   = (occ_q != '0);
    assign fifo_full    = (occ_q == DEPTH_OCC);
    assign fifo_pop     = node_valid && node_ready;
    assign fifo_push_ok = core_node_we && (!fifo_full || fifo_pop);

    assign node_data  = node_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign node_count = node_count_q;
    assign done       = done_q;
    assign at_end     = at_end_q;
    assign overflow   = overflow_q;

    assign unused_bits = ^{ext_addr[1:0], cpu_addr[1:0]};

    // Core read mux: zero on a miss, DONE reads back as a single status bit.
    always_comb begin
        cpu_rdata = 32'd0;
        if (cpu_hit) begin
            case (cpu_idx)
                IDX_START: cpu_rdata = start_q;
                IDX_END:   cpu_rdata = end_q;
                IDX_NODE:  cpu_rdata = last_node_q;
                default:   cpu_rdata = {31'd0, done_q};
            endcase
        end
    end

    // Next-state for the mailbox words, flags, counter and node FIFO.
    always_comb begin
        start_d      = start_q;
        end_d        = end_q;
        last_node_d  = last_node_q;
        done_d       = done_q;
        at_end_d     = at_end_q;
        overflow_d   = overflow_q;
        node_count_d = node_count_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        occ_d        = occ_q;

        if (host_start_we) start_d = ext_wdata;
        if (host_end_we)   end_d   = ext_wdata;

        if (core_node_we) begin
            last_node_d = cpu_wdata;
            at_end_d    = (cpu_wdata == end_q);
            if (node_count_q != '1) node_count_d = node_count_q + CNT_ONE;
            if (fifo_full && !fifo_pop) overflow_d = 1'b1;
        end

        if (core_done_we && (cpu_wdata == 32'd1)) done_d = 1'b1;

        if (host_node_we) begin
            // A host NODE write flushes the FIFO, overriding any concurrent pop.
            last_node_d = ext_wdata;
            at_end_d    = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
        end else begin
            if (fifo_push_ok) begin
                mem_d[wr_ptr_q] = cpu_wdata;
                wr_ptr_d        = wr_ptr_q + PTR_ONE;
            end
            if (fifo_pop) rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (fifo_push_ok && !fifo_pop)      occ_d = occ_q + OCC_ONE;
            else if (!fifo_push_ok && fifo_pop) occ_d = occ_q - OCC_ONE;
        end

        if (host_done_we) begin
            // A host DONE write starts a fresh run, so the run statistics clear.
            done_d       = ext_wdata[0];
            node_count_d = '0;
            overflow_d   = 1'b0;
            at_end_d     = 1'b0;
        end
    end

    // State registers; reset clears every word, flag and FIFO entry at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_q      <= '0;
            end_q        <= '0;
            last_node_q  <= '0;
            done_q       <= 1'b0;
            at_end_q     <= 1'b0;
            overflow_q   <= 1'b0;
            node_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            start_q      <= start_d;
            end_q        <= end_d;
            last_node_q  <= last_node_d;
            done_q       <= done_d;
            at_end_q     <= at_end_d;
            overflow_q   <= overflow_d;
            node_count_q <= node_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            occ_q        <= occ_d;
            mem_q        <= mem_d;
        end
    end

endmodule

// File: tb/tb_path_mailbox.sv
// Directed self-checking bench for path_mailbox.
module tb_path_mailbox;

    localparam logic [31:0] A_START = 32'h02000000;
    localparam logic [31:0] A_END   = 32'h02000004;
    localparam logic [31:0] A_NODE  = 32'h02000008;
    localparam logic [31:0] A_DONE  = 32'h0200000C;

    logic        clk;
    logic        reset_n;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [31:0] ext_wdata;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_hit;
    logic        node_valid;
    logic [31:0] node_data;
    logic        node_ready;
    logic [8:0]  node_count;
    logic        done;
    logic        at_end;
    logic        overflow;

    int total;
    int bad;

    path_mailbox #(
        .BASE_ADDR (32'h02000000),
        .FIFO_DEPTH(8),
        .CNT_W     (9)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ext_we    (ext_we),
        .ext_addr  (ext_addr),
        .ext_wdata (ext_wdata),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_hit   (cpu_hit),
        .node_valid(node_valid),
        .node_data (node_data),
        .node_ready(node_ready),
        .node_count(node_count),
        .done      (done),
        .at_end    (at_end),
        .overflow  (overflow)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%08h), want %0d (0x%08h)",
                     tag, observed, observed, expected, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic hostWrite(input logic [31:0] a, input logic [31:0] d);
        ext_we = 1'b1; ext_addr = a; ext_wdata = d;
        tick();
        ext_we = 1'b0;
    endtask

    task automatic coreWrite(input logic [31:0] a, input logic [31:0] d);
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        tick();
        cpu_we = 1'b0;
    endtask

    task automatic coreRead(input string tag, input logic [31:0] a,
                            input logic [31:0] expected);
        cpu_we = 1'b0; cpu_addr = a;
        #1;
        checkOutput(tag, cpu_rdata, expected);
    endtask

    task automatic checkFlags(input string tag, input int cnt, input logic v,
                              input logic ae, input logic ov, input logic dn);
        checkOutput({tag, ".count"},    32'(node_count), 32'(cnt));
        checkOutput({tag, ".valid"},    32'(node_valid), 32'(v));
        checkOutput({tag, ".at_end"},   32'(at_end),     32'(ae));
        checkOutput({tag, ".overflow"}, 32'(overflow),   32'(ov));
        checkOutput({tag, ".done"},     32'(done),       32'(dn));
    endtask

    initial begin
        total = 0; bad = 0;
        reset_n = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; node_ready = 1'b0;

        // Reset state
        #1;
        checkFlags("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset.node_data", node_data, 32'd0);
        coreRead("reset.rd_start", A_START, 32'd0);
        coreRead("reset.rd_node",  A_NODE,  32'd0);
        coreRead("reset.rd_done",  A_DONE,  32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("[TB] reset released");

        // START/END preload and read-back
        hostWrite(A_START, 32'd29);
        hostWrite(A_END, 32'd18);
        coreRead("rd_start", A_START, 32'd29);
        coreRead("rd_end", A_END, 32'd18);
        coreWrite(A_START, 32'd5);
        coreRead("rd_start_after_core_wr", A_START, 32'd29);
        cpu_addr = 32'h02000010;
        #1;
        checkOutput("miss.hit", 32'(cpu_hit), 32'd0);
        checkOutput("miss.rdata", cpu_rdata, 32'd0);
        cpu_addr = 32'h02000007;
        #1;
        checkOutput("lowbits.hit", 32'(cpu_hit), 32'd1);
        checkOutput("lowbits.rdata", cpu_rdata, 32'd18);

        // Three nodes queued, then drained
        tick();
        coreWrite(A_NODE, 32'd3);
        checkOutput("push1.data", node_data, 32'd3);
        coreWrite(A_NODE, 32'd7);
        coreWrite(A_NODE, 32'd18);
        checkFlags("path3", 3, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("path3.hold", node_data, 32'd3);
        coreRead("path3.rd_node", A_NODE, 32'd18);
        node_ready = 1'b1;
        #1;
        checkOutput("drain3.d0", node_data, 32'd3);
        tick();
        checkOutput("drain3.d1", node_data, 32'd7);
        tick();
        checkOutput("drain3.d2", node_data, 32'd18);
        tick();
        checkOutput("drain3.empty", 32'(node_valid), 32'd0);
        node_ready = 1'b0;

        // Overflow: nine pushes into eight entries
        hostWrite(A_DONE, 32'd0);
        checkOutput("clr.count", 32'(node_count), 32'd0);
        for (int i = 1; i <= 9; i++) coreWrite(A_NODE, 32'(i));
        checkFlags("ovf", 9, 1'b1, 1'b0, 1'b1, 1'b0);
        coreRead("ovf.rd_node", A_NODE, 32'd9);
        node_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checkOutput($sformatf("ovf.drain%0d", i), node_data, 32'(i));
            tick();
        end
        checkOutput("ovf.empty", 32'(node_valid), 32'd0);
        node_ready = 1'b0;

        // DONE handling
        coreWrite(A_DONE, 32'd2);
        checkOutput("done.wr2", 32'(done), 32'd0);
        coreWrite(A_DONE, 32'd1);
        checkOutput("done.wr1", 32'(done), 32'd1);
        coreRead("done.rd", A_DONE, 32'd1);
        hostWrite(A_DONE, 32'd0);
        checkFlags("done.clr", 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Push at full with a same-cycle pop: no overflow
        for (int i = 1; i <= 8; i++) coreWrite(A_NODE, 32'(i));
        checkFlags("full", 8, 1'b1, 1'b0, 1'b0, 1'b0);
        node_ready = 1'b1;
        coreWrite(A_NODE, 32'd9);
        checkFlags("full_pop", 9, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 2; i <= 9; i++) begin
            checkOutput($sformatf("fullpop.drain%0d", i), node_data, 32'(i));
            tick();
        end
        checkOutput("fullpop.empty", 32'(node_valid), 32'd0);
        node_ready = 1'b0;

        // Host NODE and core NODE in the same cycle: host flush wins
        coreWrite(A_NODE, 32'd5);
        checkFlags("pre_flush", 10, 1'b1, 1'b0, 1'b0, 1'b0);
        ext_we = 1'b1; ext_addr = A_NODE; ext_wdata = 32'd0;
        cpu_we = 1'b1; cpu_addr = A_NODE; cpu_wdata = 32'd12;
        tick();
        ext_we = 1'b0; cpu_we = 1'b0;
        checkFlags("flush", 10, 1'b0, 1'b0, 1'b0, 1'b0);
        coreRead("flush.rd_node", A_NODE, 32'd0);

        // Asynchronous reset mid-cycle with four entries queued
        tick();
        coreWrite(A_NODE, 32'd1);
        coreWrite(A_NODE, 32'd2);
        coreWrite(A_NODE, 32'd3);
        coreWrite(A_NODE, 32'd18);
        coreWrite(A_DONE, 32'd1);
        checkFlags("pre_rst", 14, 1'b1, 1'b1, 1'b0, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        checkFlags("async_rst", 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("async_rst.node_data", node_data, 32'd0);
        coreRead("async_rst.rd_start", A_START, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/path_mailbox.md
# path_mailbox

Memory-mapped responder sitting on the RISC-V core's data bus at base `0x02000000`. Serves the four path-planner words: start point, end point, node and CPU-done. The host side (ext_*) preloads them; the core reads them and reports its computed path by writing node values and a done flag. Node writes from the core are queued in a small FIFO and handed to the downstream navigator over a valid/ready handshake.

## Interface
Parameters:
- `BASE_ADDR`, default `32'h02000000`: block base; occupies 16 bytes.
- `FIFO_DEPTH`, default 8: node FIFO entries; power of two, ≥2.
- `CNT_W`, default 9: width of `node_count`.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ext_we`  in  1  host write strobe.
- `ext_addr`  in  32  host byte address.
- `ext_wdata`  in  32  host write data.
- `cpu_we`  in  1  core write strobe (MemWrite).
- `cpu_addr`  in  32  core byte address (DataAdr).
- `cpu_wdata`  in  32  core write data.
- `cpu_rdata`  out  32  combinational read data for `cpu_addr`.
- `cpu_hit`  out  1  combinational; `cpu_addr` decodes into this block.
- `node_valid`  out  1  FIFO non-empty.
- `node_data`  out  32  FIFO head.
- `node_ready`  in  1  navigator accepts head.
- `node_count`  out  CNT_W  core NODE writes since clear, saturating.
- `done`  out  1  CPU-done flag.
- `at_end`  out  1  last node written equals END.
- `overflow`  out  1  sticky; a NODE push was dropped.

## Operation
- Decode: hit when `addr[31:4] == BASE_ADDR[31:4]`. Word index is `addr[3:2]`; `addr[1:0]` is ignored. Index 0 START, 1 END, 2 NODE, 3 DONE. Misses have no effect, and `cpu_rdata` is 0 on a miss.
- START/END:
  - Host write loads the full 32 bits.
  - Core writes are ignored.
  - Core reads return the value.
- NODE, core write:
  - `last_node <= wdata`.
  - Push `wdata` into the FIFO.
  - `node_count` increments, saturating at all-ones.
  - `at_end <= (wdata == END)`.
- NODE, core read: returns `last_node`.
- NODE, host write:
  - `last_node <= wdata`.
  - FIFO flushed (empty).
  - `at_end <= 0`.
- DONE, core write: `done <= 1` only if `wdata == 1`. Other values are ignored.
- DONE, host write:
  - `done <= wdata[0]`.
  - `node_count <= 0`, `overflow <= 0`, `at_end <= 0`.
- DONE, core read: returns `{31'b0, done}`.
- FIFO: registered storage with wrapping read/write pointers and an occupancy counter.
  - Pop when `node_valid && node_ready`.
  - Push while full and no pop in the same cycle: data dropped, `overflow <= 1`. `last_node`, `node_count` and `at_end` still update.
  - Push while full with a pop in the same cycle: accepted, occupancy unchanged.
  - Push and pop on a non-empty, non-full FIFO: both performed.
  - Pop on empty is impossible (`node_valid = 0`).
- Simultaneous host and core write to the same word: host wins, core write discarded entirely (no push, no count). Different words: both take effect.
- Host write to NODE concurrent with a pop: flush wins.

## Timing
- Reset (async assert, sync-to-clk deassert not required):
  - All registers 0, FIFO empty.
  - `node_valid=0`, `node_data=0`, `done=0`, `at_end=0`, `overflow=0`, `node_count=0`.
  - `cpu_rdata` = 0 for every address.
- Write latency: a register written at edge N is visible on `cpu_rdata` and outputs after edge N (same-cycle read sees the old value).
- Push at edge N → `node_valid=1` and `node_data` valid after edge N.
- Pop at edge N → next entry (or `node_valid=0`) after edge N.
- `node_data` holds stable while `node_valid && !node_ready`.
- `cpu_rdata` and `cpu_hit` are purely combinational from `cpu_addr` and registers; no bus wait states.
- Reset mid-stream discards FIFO contents and all flags immediately.

## Test plan
- Reset → host writes START=29 (0x02000000), END=18 (0x02000004) → core reads 0x02000000 → 29 and 0x02000004 → 18. Core write 5 to START → read still 29.
- `node_ready=0`, core writes NODE 3, 7, 18 → `node_count=3`, `at_end=1`, NODE read =18. Raise `node_ready` → `node_data` 3, 7, 18 on consecutive cycles, then `node_valid=0`.
- `FIFO_DEPTH=8`, `ready=0`, 9 NODE writes (1..9) → `overflow=1`, `node_count=9`, FIFO drains 1..8. Repeat at full with `ready=1` on the 9th write → no overflow.
- Core writes DONE 2 → `done=0`; writes 1 → `done=1`, read 0x0200000c = 1. Host writes DONE 0 → `done=0`, `node_count=0`, `overflow=0`.
- Same cycle: host writes NODE 0 while core writes NODE 12 → `last_node=0`, FIFO empty, `node_count` unchanged.
- Assert `reset_n=0` mid-cycle with 4 entries queued → outputs 0 immediately, without waiting for a clock edge.
